// File: rtl/pulse_train_gen.sv
// Pulse train generator: accepts a count N and replays it as N single-beat strobes on a
// valid/ready output, separated by a programmable number of idle cycles.

module pulse_train_gen_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             clear_i,
  input logic             pulse_o,
  input logic             pulse_ready_i,
  input logic [WIDTH-1:0] remaining_o,
  input logic             busy_o,
  input logic             done_o
);

  // A stalled strobe must hold, unless an abort intervenes.
  a_stall_hold: assert property (@(posedge clk_i)
    (!rst_i && !clear_i && pulse_o && !pulse_ready_i) |=> (pulse_o && $stable(remaining_o)));

  a_done_single: assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |=> !done_o);

  a_idle_empty: assert property (@(posedge clk_i)
    !busy_o |-> (remaining_o == {WIDTH{1'b0}}));

endmodule

module pulse_train_gen #(
  parameter int WIDTH     = 8,
  parameter int GAP_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 cnt_valid_i,
  output logic                 cnt_ready_o,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic [GAP_WIDTH-1:0] gap_i,
  output logic                 pulse_o,
  input  logic                 pulse_ready_i,
  output logic [WIDTH-1:0]     remaining_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     remaining_q, remaining_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic                 done_q, done_d;
  logic                 accept_s;
  logic                 fire_s;
  logic                 last_s;

  assign accept_s = cnt_valid_i & cnt_ready_o;
  assign fire_s   = (state_q == ST_EMIT) & pulse_ready_i;
  assign last_s   = (remaining_q == WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= {WIDTH{1'b0}};
      gap_q       <= {GAP_WIDTH{1'b0}};
      gap_cnt_q   <= {GAP_WIDTH{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && (cnt_i != {WIDTH{1'b0}})) state_d = ST_EMIT;
          else                                      state_d = ST_IDLE;
        end
        ST_EMIT: begin
          if (!fire_s)                          state_d = ST_EMIT;
          else if (last_s)                      state_d = ST_IDLE;
          else if (gap_q == {GAP_WIDTH{1'b0}})  state_d = ST_EMIT;
          else                                  state_d = ST_GAP;
        end
        ST_GAP: begin
          // A zero count here cannot happen in normal flow; treat it as expired.
          if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = ST_EMIT;
          else                            state_d = ST_GAP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    if (clear_i) begin
      remaining_d = {WIDTH{1'b0}};
      gap_cnt_d   = {GAP_WIDTH{1'b0}};
    end else if (accept_s) begin
      remaining_d = cnt_i;
      gap_d       = gap_i;
      gap_cnt_d   = {GAP_WIDTH{1'b0}};
      done_d      = (cnt_i == {WIDTH{1'b0}});
    end else if (fire_s) begin
      // Saturating decrement: the count never wraps below zero.
      if (remaining_q != {WIDTH{1'b0}}) remaining_d = remaining_q - WIDTH'(1);
      else                              remaining_d = remaining_q;
      if (last_s) gap_cnt_d = {GAP_WIDTH{1'b0}};
      else        gap_cnt_d = gap_q;
      done_d = last_s;
    end else if (state_q == ST_GAP) begin
      if (gap_cnt_q != {GAP_WIDTH{1'b0}}) gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      else                                gap_cnt_d = gap_cnt_q;
    end else begin
      done_d = 1'b0;
    end
  end

  always_comb begin
    cnt_ready_o = (state_q == ST_IDLE) & ~rst_i & ~clear_i;
    pulse_o     = (state_q == ST_EMIT);
    busy_o      = (state_q != ST_IDLE);
    remaining_o = remaining_q;
    done_o      = done_q;
  end

  pulse_train_gen_chk #(.WIDTH(WIDTH)) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .pulse_o       (pulse_o),
    .pulse_ready_i (pulse_ready_i),
    .remaining_o   (remaining_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen with hand-computed cycle-by-cycle expectations.

module tb_pulse_train_gen;

  logic       clk;
  logic       rst_i;
  logic       clear_i;
  logic       cnt_valid_i;
  logic       cnt_ready_o;
  logic [7:0] cnt_i;
  logic [3:0] gap_i;
  logic       pulse_o;
  logic       pulse_ready_i;
  logic [7:0] remaining_o;
  logic       busy_o;
  logic       done_o;

  int checks;
  int failures;

  pulse_train_gen #(.WIDTH(8), .GAP_WIDTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .cnt_valid_i   (cnt_valid_i),
    .cnt_ready_o   (cnt_ready_o),
    .cnt_i         (cnt_i),
    .gap_i         (gap_i),
    .pulse_o       (pulse_o),
    .pulse_ready_i (pulse_ready_i),
    .remaining_o   (remaining_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic p, input logic [7:0] r,
                            input logic b, input logic d);
    check_eq({tag, ".pulse"}, 32'(pulse_o), 32'(p));
    check_eq({tag, ".rem"},   32'(remaining_o), 32'(r));
    check_eq({tag, ".busy"},  32'(busy_o), 32'(b));
    check_eq({tag, ".done"},  32'(done_o), 32'(d));
  endtask

  task automatic expect_ready(input string tag, input logic r);
    #1;
    check_eq({tag, ".ready"}, 32'(cnt_ready_o), 32'(r));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_i = 1'b1; clear_i = 1'b0; cnt_valid_i = 1'b0; cnt_i = 8'd0; gap_i = 4'd0;
    pulse_ready_i = 1'b1;
    tick; tick;
    expect_out("reset", 1'b0, 8'd0, 1'b0, 1'b0);
    expect_ready("reset", 1'b0);
    rst_i = 1'b0;
    expect_ready("post_reset", 1'b1);

    // 1: cnt=3 gap=0, full throughput
    cnt_valid_i = 1'b1; cnt_i = 8'd3; gap_i = 4'd0;
    tick;
    cnt_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_out("t1", (i <= 3), 8'(4 - i), (i <= 3), (i == 4));
      tick;
    end
    expect_out("t1.after", 1'b0, 8'd0, 1'b0, 1'b0);

    // 2: cnt=2 gap=2
    cnt_valid_i = 1'b1; cnt_i = 8'd2; gap_i = 4'd2;
    tick;
    cnt_valid_i = 1'b0;
    expect_out("t2.c1", 1'b1, 8'd2, 1'b1, 1'b0); tick;
    expect_out("t2.c2", 1'b0, 8'd1, 1'b1, 1'b0); tick;
    expect_out("t2.c3", 1'b0, 8'd1, 1'b1, 1'b0); tick;
    expect_out("t2.c4", 1'b1, 8'd1, 1'b1, 1'b0); tick;
    expect_out("t2.c5", 1'b0, 8'd0, 1'b0, 1'b1); tick;
    expect_out("t2.c6", 1'b0, 8'd0, 1'b0, 1'b0);

    // 3: cnt=0 completes immediately with no strobe
    cnt_valid_i = 1'b1; cnt_i = 8'd0; gap_i = 4'd0;
    expect_ready("t3.c0", 1'b1);
    tick;
    cnt_valid_i = 1'b0;
    expect_out("t3.c1", 1'b0, 8'd0, 1'b0, 1'b1);
    expect_ready("t3.c1", 1'b1);
    tick;
    expect_out("t3.c2", 1'b0, 8'd0, 1'b0, 1'b0);
    expect_ready("t3.c2", 1'b1);

    // 4: consumer stalls for the first three EMIT cycles
    cnt_valid_i = 1'b1; cnt_i = 8'd2; gap_i = 4'd0; pulse_ready_i = 1'b0;
    tick;
    cnt_valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      expect_out("t4.stall", 1'b1, 8'd2, 1'b1, 1'b0);
      tick;
    end
    pulse_ready_i = 1'b1;
    expect_out("t4.c4", 1'b1, 8'd2, 1'b1, 1'b0); tick;
    expect_out("t4.c5", 1'b1, 8'd1, 1'b1, 1'b0); tick;
    expect_out("t4.c6", 1'b0, 8'd0, 1'b0, 1'b1); tick;
    expect_out("t4.c7", 1'b0, 8'd0, 1'b0, 1'b0);

    // 5: clear after first handshake; request during clear is ignored
    cnt_valid_i = 1'b1; cnt_i = 8'd5; gap_i = 4'd0;
    tick;
    cnt_valid_i = 1'b0;
    expect_out("t5.c1", 1'b1, 8'd5, 1'b1, 1'b0); tick;
    expect_out("t5.c2", 1'b1, 8'd4, 1'b1, 1'b0);
    clear_i = 1'b1; cnt_valid_i = 1'b1; cnt_i = 8'd7;
    expect_ready("t5.clr", 1'b0);
    tick;
    expect_out("t5.c3", 1'b0, 8'd0, 1'b0, 1'b0);
    clear_i = 1'b0; cnt_valid_i = 1'b0;
    tick;
    expect_out("t5.c4", 1'b0, 8'd0, 1'b0, 1'b0);

    // 6: back-to-back request accepted in the done cycle, then a full-range run
    cnt_valid_i = 1'b1; cnt_i = 8'd2; gap_i = 4'd0;
    tick;
    cnt_i = 8'd255;
    expect_out("t6.c1", 1'b1, 8'd2, 1'b1, 1'b0);
    expect_ready("t6.c1", 1'b0);
    tick;
    expect_out("t6.c2", 1'b1, 8'd1, 1'b1, 1'b0); tick;
    expect_out("t6.c3", 1'b0, 8'd0, 1'b0, 1'b1);
    expect_ready("t6.c3", 1'b1);
    tick;
    cnt_valid_i = 1'b0;
    for (int i = 0; i < 255; i++) begin
      check_eq("t6.pulse", 32'(pulse_o), 32'd1);
      check_eq("t6.rem", 32'(remaining_o), 32'(255 - i));
      tick;
    end
    expect_out("t6.end", 1'b0, 8'd0, 1'b0, 1'b1); tick;
    expect_out("t6.end1", 1'b0, 8'd0, 1'b0, 1'b0);

    // reset in the middle of a run
    cnt_valid_i = 1'b1; cnt_i = 8'd10; gap_i = 4'd1;
    tick;
    cnt_valid_i = 1'b0;
    expect_out("t6r.c1", 1'b1, 8'd10, 1'b1, 1'b0); tick;
    expect_out("t6r.c2", 1'b0, 8'd9, 1'b1, 1'b0); tick;
    expect_out("t6r.c3", 1'b1, 8'd9, 1'b1, 1'b0);
    rst_i = 1'b1;
    tick;
    expect_out("t6r.rst", 1'b0, 8'd0, 1'b0, 1'b0);
    expect_ready("t6r.rst", 1'b0);
    rst_i = 1'b0;
    tick;
    expect_out("t6r.post", 1'b0, 8'd0, 1'b0, 1'b0);
    expect_ready("t6r.post", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
